inst_decode_stage: RTL and testbench

INST_DECODE_STAGE -- requirements
Module: inst_decode_stage

---
 rtl/inst_decode_stage.sv | 164 ++++++++++++++++
 tb/tb_inst_decode_stage.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_decode_stage.sv
// Instruction decode stage: decodes the offered word into register indices, immediate and
// class, then passes it on through a one-deep output register backed by a single skid entry.
module inst_decode_stage #(
    parameter bit STRICT_ALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if2id_valid,
    input  logic [31:0] if2id_pc,
    input  logic [31:0] if2id_inst,
    output logic        if2id_ready,
    input  logic        flush,
    input  logic        id2ex_ready,
    output logic        id2ex_valid,
    output logic [31:0] id2ex_pc,
    output logic [4:0]  id2ex_rd,
    output logic [4:0]  id2ex_rs1,
    output logic [4:0]  id2ex_rs2,
    output logic [31:0] id2ex_imm,
    output logic [3:0]  id2ex_type,
    output logic [3:0]  id2ex_funct,
    output logic [31:0] id2ex_count
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REGW  = 5;
    localparam int unsigned TYPEW = 4;

    localparam logic [TYPEW-1:0] T_OP     = 4'd0;
    localparam logic [TYPEW-1:0] T_OPIMM  = 4'd1;
    localparam logic [TYPEW-1:0] T_LOAD   = 4'd2;
    localparam logic [TYPEW-1:0] T_STORE  = 4'd3;
    localparam logic [TYPEW-1:0] T_BRANCH = 4'd4;
    localparam logic [TYPEW-1:0] T_JAL    = 4'd5;
    localparam logic [TYPEW-1:0] T_JALR   = 4'd6;
    localparam logic [TYPEW-1:0] T_LUI    = 4'd7;
    localparam logic [TYPEW-1:0] T_AUIPC  = 4'd8;
    localparam logic [TYPEW-1:0] T_FENCE  = 4'd9;
    localparam logic [TYPEW-1:0] T_SYSTEM = 4'd10;
    localparam logic [TYPEW-1:0] T_ILL    = 4'd15;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [REGW-1:0]  rd;
        logic [REGW-1:0]  rs1;
        logic [REGW-1:0]  rs2;
        logic [XLEN-1:0]  imm;
        logic [TYPEW-1:0] typ;
        logic [3:0]       funct;
    } dec_t;

    dec_t            dec_c;
    dec_t            out_q, out_d, skid_q, skid_d;
    logic            out_valid_q, out_valid_d;
    logic            skid_valid_q, skid_valid_d;
    logic            ready_q, ready_d;
    logic [XLEN-1:0] count_q, count_d;
    logic            accept_c, drain_c;

    // Decode of the presented word; class first, then the immediate selected by class.
    always_comb begin
        dec_c       = '0;
        dec_c.pc    = if2id_pc;
        dec_c.rd    = if2id_inst[11:7];
        dec_c.rs1   = if2id_inst[19:15];
        dec_c.rs2   = if2id_inst[24:20];
        dec_c.funct = {if2id_inst[30], if2id_inst[14:12]};
        case (if2id_inst[6:0])
            7'b0110011: dec_c.typ = T_OP;
            7'b0010011: dec_c.typ = T_OPIMM;
            7'b0000011: dec_c.typ = T_LOAD;
            7'b0100011: dec_c.typ = T_STORE;
            7'b1100011: dec_c.typ = T_BRANCH;
            7'b1101111: dec_c.typ = T_JAL;
            7'b1100111: dec_c.typ = T_JALR;
            7'b0110111: dec_c.typ = T_LUI;
            7'b0010111: dec_c.typ = T_AUIPC;
            7'b0001111: dec_c.typ = T_FENCE;
            7'b1110011: dec_c.typ = T_SYSTEM;
            default:    dec_c.typ = T_ILL;
        endcase
        if (STRICT_ALIGN && (if2id_pc[1:0] != 2'b00)) begin
            dec_c.typ = T_ILL;
        end
        case (dec_c.typ)
            T_OPIMM, T_LOAD, T_JALR, T_SYSTEM:
                dec_c.imm = {{20{if2id_inst[31]}}, if2id_inst[31:20]};
            T_STORE:
                dec_c.imm = {{20{if2id_inst[31]}}, if2id_inst[31:25], if2id_inst[11:7]};
            T_BRANCH:
                dec_c.imm = {{19{if2id_inst[31]}}, if2id_inst[31], if2id_inst[7],
                             if2id_inst[30:25], if2id_inst[11:8], 1'b0};
            T_LUI, T_AUIPC:
                dec_c.imm = {if2id_inst[31:12], 12'b0};
            T_JAL:
                dec_c.imm = {{11{if2id_inst[31]}}, if2id_inst[31], if2id_inst[19:12],
                             if2id_inst[20], if2id_inst[30:21], 1'b0};
            default:
                dec_c.imm = '0;
        endcase
    end

    assign accept_c = if2id_valid & ready_q;
    assign drain_c  = out_valid_q & id2ex_ready;

    // Next-state for output register and skid; ready_q tracks skid emptiness so no
    // accept can coincide with a full skid.
    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        count_d      = count_q + XLEN'(drain_c);
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || drain_c) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept_c) begin
                out_d       = dec_c;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept_c) begin
            skid_d       = dec_c;
            skid_valid_d = 1'b1;
        end
        ready_d = ~skid_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b0;
            count_q      <= '0;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= ready_d;
            count_q      <= count_d;
        end
    end

    assign if2id_ready = ready_q;
    assign id2ex_valid = out_valid_q;
    assign id2ex_pc    = out_q.pc;
    assign id2ex_rd    = out_q.rd;
    assign id2ex_rs1   = out_q.rs1;
    assign id2ex_rs2   = out_q.rs2;
    assign id2ex_imm   = out_q.imm;
    assign id2ex_type  = out_q.typ;
    assign id2ex_funct = out_q.funct;
    assign id2ex_count = count_q;

endmodule

// File: tb/tb_inst_decode_stage.sv
// Scoreboard bench for inst_decode_stage: decoded results are queued at each accepted input
// and compared in order at each id2ex transfer.
module tb_inst_decode_stage;

    logic        clk;
    logic        rst_n;
    logic        if2id_valid;
    logic [31:0] if2id_pc;
    logic [31:0] if2id_inst;
    logic        if2id_ready;
    logic        flush;
    logic        id2ex_ready;
    logic        id2ex_valid;
    logic [31:0] id2ex_pc;
    logic [4:0]  id2ex_rd;
    logic [4:0]  id2ex_rs1;
    logic [4:0]  id2ex_rs2;
    logic [31:0] id2ex_imm;
    logic [3:0]  id2ex_type;
    logic [3:0]  id2ex_funct;
    logic [31:0] id2ex_count;

    inst_decode_stage #(.STRICT_ALIGN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .if2id_valid(if2id_valid), .if2id_pc(if2id_pc), .if2id_inst(if2id_inst),
        .if2id_ready(if2id_ready), .flush(flush), .id2ex_ready(id2ex_ready),
        .id2ex_valid(id2ex_valid), .id2ex_pc(id2ex_pc), .id2ex_rd(id2ex_rd),
        .id2ex_rs1(id2ex_rs1), .id2ex_rs2(id2ex_rs2), .id2ex_imm(id2ex_imm),
        .id2ex_type(id2ex_type), .id2ex_funct(id2ex_funct), .id2ex_count(id2ex_count)
    );

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic [3:0]  typ;
        logic [3:0]  funct;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] mcount = 0;
    bit          last_in = 0;
    bit          hold_pending = 0;
    logic [31:0] hold_pc, hold_imm;
    bit          rnd_ready = 0;
    logic [31:0] saved_count;
    logic [31:0] insts[16] = '{
        32'h00500093, 32'hFE000EE3, 32'h00000000, 32'h002081B3,
        32'h40208233, 32'h0040A103, 32'hFE112E23, 32'h123452B7,
        32'h00001317, 32'hFF5FF0EF, 32'h000080E7, 32'h0FF0000F,
        32'h00000073, 32'h0000007F, 32'h00500090, 32'h80000013
    };

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Independent reference decode, written from the class table and immediate formats.
    function automatic exp_t model(input logic [31:0] pc, input logic [31:0] i);
        exp_t e;
        e.pc = pc; e.rd = i[11:7]; e.rs1 = i[19:15]; e.rs2 = i[24:20];
        e.funct = {i[30], i[14:12]};
        if (i[1:0] != 2'b11 || pc[1:0] != 2'b00) e.typ = 4'd15;
        else begin
            case (i[6:2])
                5'b01100: e.typ = 4'd0;
                5'b00100: e.typ = 4'd1;
                5'b00000: e.typ = 4'd2;
                5'b01000: e.typ = 4'd3;
                5'b11000: e.typ = 4'd4;
                5'b11011: e.typ = 4'd5;
                5'b11001: e.typ = 4'd6;
                5'b01101: e.typ = 4'd7;
                5'b00101: e.typ = 4'd8;
                5'b00011: e.typ = 4'd9;
                5'b11100: e.typ = 4'd10;
                default:  e.typ = 4'd15;
            endcase
        end
        case (e.typ)
            4'd1, 4'd2, 4'd6, 4'd10: e.imm = 32'($signed(i[31:20]));
            4'd3: e.imm = 32'($signed({i[31:25], i[11:7]}));
            4'd4: e.imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
            4'd7, 4'd8: e.imm = {i[31:12], 12'h000};
            4'd5: e.imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
            default: e.imm = 32'h0;
        endcase
        return e;
    endfunction

    // One clock: observe pre-edge handshakes at negedge, update scoreboard, step to posedge+1.
    task automatic tick();
        bit   in_x, out_x;
        exp_t e;
        @(negedge clk);
        in_x  = if2id_valid && if2id_ready;
        out_x = id2ex_valid && id2ex_ready;
        check_val("count", id2ex_count, mcount);
        if (hold_pending) begin
            check_val("hold_valid", 32'(id2ex_valid), 32'd1);
            check_val("hold_pc", id2ex_pc, hold_pc);
            check_val("hold_imm", id2ex_imm, hold_imm);
        end
        if (out_x) begin
            check_val("out_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check_val("pc", id2ex_pc, e.pc);
                check_val("type", 32'(id2ex_type), 32'(e.typ));
                check_val("rd", 32'(id2ex_rd), 32'(e.rd));
                check_val("rs1", 32'(id2ex_rs1), 32'(e.rs1));
                check_val("rs2", 32'(id2ex_rs2), 32'(e.rs2));
                check_val("imm", id2ex_imm, e.imm);
                check_val("funct", 32'(id2ex_funct), 32'(e.funct));
            end
            mcount = mcount + 32'd1;
        end
        if (flush) sb.delete();
        else if (in_x) sb.push_back(model(if2id_pc, if2id_inst));
        hold_pending = id2ex_valid && !id2ex_ready && !flush;
        hold_pc      = id2ex_pc;
        hold_imm     = id2ex_imm;
        last_in      = in_x;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] pc, input logic [31:0] inst);
        bit done = 0;
        if2id_valid = 1'b1; if2id_pc = pc; if2id_inst = inst;
        for (int n = 0; n < 50 && !done; n++) begin
            if (rnd_ready) id2ex_ready = ($urandom_range(0, 3) != 0);
            tick();
            done = last_in;
        end
        if2id_valid = 1'b0;
        check_val("send_accepted", 32'(done), 32'd1);
    endtask

    task automatic drain();
        if2id_valid = 1'b0;
        id2ex_ready = 1'b1;
        for (int n = 0; n < 10 && (sb.size() != 0 || id2ex_valid); n++) tick();
        check_val("drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; if2id_valid = 1'b0; if2id_pc = '0; if2id_inst = '0;
        flush = 1'b0; id2ex_ready = 1'b0;
        #12;
        check_val("rst_valid", 32'(id2ex_valid), 32'd0);
        check_val("rst_ready", 32'(if2id_ready), 32'd0);
        check_val("rst_count", id2ex_count, 32'd0);
        check_val("rst_pc", id2ex_pc, 32'd0);
        check_val("rst_imm", id2ex_imm, 32'd0);
        check_val("rst_type", 32'(id2ex_type), 32'd0);

        @(negedge clk); rst_n = 1'b1; #1;
        check_val("ready_before_edge", 32'(if2id_ready), 32'd0);
        @(posedge clk); #1;
        check_val("ready_after_release", 32'(if2id_ready), 32'd1);

        // Single ADDI x1, x0, 5 with downstream always ready.
        id2ex_ready = 1'b1;
        if2id_valid = 1'b1; if2id_pc = 32'h0; if2id_inst = 32'h00500093;
        tick();
        if2id_valid = 1'b0;
        check_val("addi_valid", 32'(id2ex_valid), 32'd1);
        check_val("addi_type", 32'(id2ex_type), 32'd1);
        check_val("addi_rd", 32'(id2ex_rd), 32'd1);
        check_val("addi_rs1", 32'(id2ex_rs1), 32'd0);
        check_val("addi_imm", id2ex_imm, 32'd5);
        tick();
        check_val("addi_count", id2ex_count, 32'd1);

        // Back-to-back under back-pressure fills output and skid.
        id2ex_ready = 1'b0;
        if2id_valid = 1'b1; if2id_pc = 32'h0; if2id_inst = 32'h00500093;
        tick();
        if2id_pc = 32'h4; if2id_inst = 32'h002081B3;
        tick();
        if2id_valid = 1'b0;
        check_val("skid_full_ready", 32'(if2id_ready), 32'd0);
        check_val("skid_full_pc", id2ex_pc, 32'h0);
        tick(); tick();
        drain();

        // Every table entry, then a misaligned ADDI.
        foreach (insts[k]) send(32'h1000 + 32'(k) * 32'd4, insts[k]);
        send(32'h2, 32'h00500093);
        drain();

        // Random stream with random back-pressure and occasional misaligned pc.
        rnd_ready = 1;
        for (int k = 0; k < 40; k++)
            send({$urandom_range(0, 32'hFFFF), ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00},
                 insts[$urandom_range(0, 15)]);
        rnd_ready = 0;
        drain();

        // Flush with both entries full and a simultaneous offer.
        id2ex_ready = 1'b0;
        if2id_valid = 1'b1; if2id_pc = 32'h100; if2id_inst = 32'h00500093;
        tick();
        if2id_pc = 32'h104; if2id_inst = 32'h40208233;
        tick();
        check_val("pre_flush_ready", 32'(if2id_ready), 32'd0);
        saved_count = mcount;
        flush = 1'b1; if2id_pc = 32'h108; if2id_inst = 32'h123452B7;
        tick();
        flush = 1'b0; if2id_valid = 1'b0;
        check_val("flush_valid", 32'(id2ex_valid), 32'd0);
        check_val("flush_ready", 32'(if2id_ready), 32'd1);
        check_val("flush_count", id2ex_count, saved_count);
        id2ex_ready = 1'b1;
        tick(); tick();

        // Asynchronous reset mid-stream with skid full.
        id2ex_ready = 1'b0;
        if2id_valid = 1'b1; if2id_pc = 32'h200; if2id_inst = 32'h0040A103;
        tick();
        if2id_pc = 32'h204; if2id_inst = 32'hFE112E23;
        tick();
        if2id_valid = 1'b0;
        #2 rst_n = 1'b0; #1;
        check_val("arst_valid", 32'(id2ex_valid), 32'd0);
        check_val("arst_ready", 32'(if2id_ready), 32'd0);
        check_val("arst_count", id2ex_count, 32'd0);
        check_val("arst_pc", id2ex_pc, 32'd0);
        check_val("arst_imm", id2ex_imm, 32'd0);
        sb.delete(); mcount = 0; hold_pending = 0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check_val("arst_ready_release", 32'(if2id_ready), 32'd1);
        rnd_ready = 1;
        foreach (insts[k]) send(32'h3000 + 32'(k) * 32'd4, insts[k]);
        rnd_ready = 0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
